// File: rtl/muldiv_if.sv
// Issue, MTHI/MTLO and result bus between the EX stage and the sequential
// multiply/divide unit.
interface muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        rd_hilo;
    logic        flush;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, opa, opb, hi_we, lo_we, wdata, rd_hilo, flush,
        input  busy, stall_req, done, hi, lo
    );

    modport slave (
        input  start, op, opa, opb, hi_we, lo_we, wdata, rd_hilo, flush,
        output busy, stall_req, done, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Sequential radix-2 MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Fixed 33-cycle latency: load, 32 iteration steps, then sign fix-up and write-back.
module muldiv_seq (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        div_q, div_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic        neg_lo_q, neg_lo_d;
    logic        neg_hi_q, neg_hi_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        is_signed, a_neg, b_neg;
    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum;
    logic [32:0] div_diff;
    logic [63:0] prod;
    logic [31:0] quo, rem;

    always_comb begin
        is_signed = ~bus.op[0];
        a_neg     = is_signed & bus.opa[31];
        b_neg     = is_signed & bus.opb[31];
        abs_a     = a_neg ? (32'd0 - bus.opa) : bus.opa;
        abs_b     = b_neg ? (32'd0 - bus.opb) : bus.opb;
        mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
        // Bit 32 is the borrow: partial remainder stays below 2*divisor.
        div_diff  = acc_q[63:31] - {1'b0, opnd_q};
        prod      = neg_lo_q ? (64'd0 - acc_q) : acc_q;
        quo       = neg_lo_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        rem       = neg_hi_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.hi_we) hi_d = bus.wdata;
                if (bus.lo_we) lo_d = bus.wdata;
                if (bus.start && !bus.flush) begin
                    state_d = StCalc;
                    cnt_d   = 6'd0;
                    div_d   = bus.op[1];
                    acc_d   = {32'd0, abs_a};
                    opnd_d  = abs_b;
                    if (bus.op[1]) begin
                        // Divide by zero keeps an all-ones quotient regardless of sign.
                        neg_lo_d = (a_neg ^ b_neg) & (|bus.opb);
                        neg_hi_d = a_neg;
                    end else begin
                        neg_lo_d = a_neg ^ b_neg;
                        neg_hi_d = 1'b0;
                    end
                end
            end

            StCalc: begin
                if (bus.flush) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                    if (div_q) begin
                        if (div_diff[32]) acc_d = {acc_q[62:0], 1'b0};
                        else              acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
                    end else begin
                        if (acc_q[0]) acc_d = {mul_sum, acc_q[31:1]};
                        else          acc_d = {1'b0, acc_q[63:1]};
                    end
                    if (cnt_q == 6'd31) state_d = StFin;
                end
            end

            StFin: begin
                state_d = StIdle;
                if (!bus.flush) begin
                    done_d = 1'b1;
                    if (div_q) begin
                        hi_d = rem;
                        lo_d = quo;
                    end else begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 6'd0;
            div_q    <= 1'b0;
            acc_q    <= 64'd0;
            opnd_q   <= 32'd0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy      = (state_q != StIdle);
    assign bus.stall_req = bus.busy & (bus.start | bus.rd_hilo | bus.hi_we | bus.lo_we);
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized bench for muldiv_seq against a plain-arithmetic HI/LO model,
// plus directed stall, flush, MTHI collision and mid-operation reset scenarios.
module tb_muldiv_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_if bus ();

    muldiv_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns {hi, lo} as the architecture defines them.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int          sa, sb;
        logic [63:0] r;
        sa = a;
        sb = b;
        case (op)
            2'd0: r = longint'(sa) * longint'(sb);
            2'd1: r = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                else r = {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    task automatic clear_inputs();
        bus.start   = 1'b0;
        bus.op      = 2'd0;
        bus.opa     = 32'd0;
        bus.opb     = 32'd0;
        bus.hi_we   = 1'b0;
        bus.lo_we   = 1'b0;
        bus.wdata   = 32'd0;
        bus.rd_hilo = 1'b0;
        bus.flush   = 1'b0;
    endtask

    // Issue one op, then track busy/done over E0..E35 and check the result at E33.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [63:0] exp;
        int          busy_n, done_n, done_at;
        exp = model(op, a, b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opa   = a;
        bus.opb   = b;
        busy_n    = 0;
        done_n    = 0;
        done_at   = -1;
        for (int k = 0; k < 36; k++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                done_at = k;
            end
            if (k == 33) check_eq({tag, " hilo"}, {bus.hi, bus.lo}, exp);
        end
        check_eq({tag, " busy_cycles"}, 64'(busy_n), 64'd33);
        check_eq({tag, " done_count"}, 64'(done_n), 64'd1);
        check_eq({tag, " done_edge"}, 64'(done_at), 64'd33);
    endtask

    initial begin
        logic [63:0] exp;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          done_n;

        clear_inputs();
        #2;
        check_eq("reset hilo", {bus.hi, bus.lo}, 64'd0);
        check_eq("reset busy", 64'(bus.busy), 64'd0);
        check_eq("reset done", 64'(bus.done), 64'd0);
        check_eq("reset stall", 64'(bus.stall_req), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("multu 3x5", 2'd1, 32'd3, 32'd5);
        run_op("mult -2x3", 2'd0, 32'hFFFF_FFFE, 32'd3);
        run_op("multu fffffffe x3", 2'd1, 32'hFFFF_FFFE, 32'd3);
        run_op("div -7/2", 2'd2, 32'hFFFF_FFF9, 32'd2);
        run_op("divu 7/0", 2'd3, 32'd7, 32'd0);
        run_op("div ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div -9/0", 2'd2, 32'hFFFF_FFF7, 32'd0);
        run_op("mult minxmin", 2'd0, 32'h8000_0000, 32'h8000_0000);

        for (int i = 0; i < 20; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
        end

        // MFHI waiting on a busy unit stalls until the result lands; MTHI while busy is dropped.
        exp = model(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'd1;
        bus.opa   = 32'h1234_5678;
        bus.opb   = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 1; k < 35; k++) begin
            @(negedge clk);
            if (k == 5) begin
                bus.rd_hilo = 1'b1;
                bus.hi_we   = 1'b1;
                bus.wdata   = 32'hDEAD_BEEF;
            end
            if (k == 6) bus.hi_we = 1'b0;
            @(posedge clk);
            #1;
            if (k >= 5) check_eq($sformatf("stall e%0d", k), 64'(bus.stall_req), 64'(k < 33));
            if (k == 33) check_eq("stall hilo", {bus.hi, bus.lo}, exp);
        end
        bus.rd_hilo = 1'b0;

        // Flush mid-divide leaves preloaded HI/LO intact and suppresses done.
        @(negedge clk);
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000_AAAA;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.wdata = 32'h0000_5555;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check_eq("mthi preload", {bus.hi, bus.lo}, {32'h0000_AAAA, 32'h0000_5555});
        bus.start = 1'b1;
        bus.op    = 2'd2;
        bus.opa   = 32'd100;
        bus.opb   = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check_eq("flush busy", 64'(bus.busy), 64'd0);
        done_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_n++;
        end
        check_eq("flush no done", 64'(done_n), 64'd0);
        check_eq("flush hilo", {bus.hi, bus.lo}, {32'h0000_AAAA, 32'h0000_5555});
        run_op("div after flush", 2'd2, 32'd100, 32'd7);

        // Flush together with start in IDLE: the op never begins.
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check_eq("flush+start busy", 64'(bus.busy), 64'd0);

        // MTHI in the start cycle lands immediately, then the result overwrites it.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'd1;
        bus.opa   = 32'd6;
        bus.opb   = 32'd7;
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_1111;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        check_eq("mthi+start hi", 64'(bus.hi), 64'h1111);
        repeat (33) @(posedge clk);
        #1;
        check_eq("mthi+start result", {bus.hi, bus.lo}, {32'd0, 32'd42});

        // Reset during CALC abandons the op at once with no later done.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'd0;
        bus.opa   = 32'hFFFF_FFFB;
        bus.opb   = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst hilo", {bus.hi, bus.lo}, 64'd0);
        check_eq("rst busy", 64'(bus.busy), 64'd0);
        check_eq("rst done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        done_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) done_n++;
        end
        check_eq("rst no resume", 64'(done_n), 64'd0);
        run_op("mult after rst", 2'd0, 32'hFFFF_FFFB, 32'd9);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock of the pipeline.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port start, input, 1, EX-stage mult/div issue request.
REQ-004 SHALL have port op, input, 2, operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port opa, input, 32, forwarded rs operand.
REQ-006 SHALL have port opb, input, 32, forwarded rt operand.
REQ-007 SHALL have port hi_we / lo_we, input, 1 each, MTHI / MTLO write enables.
REQ-008 SHALL have port wdata, input, 32, MTHI/MTLO write data.
REQ-009 SHALL have port rd_hilo, input, 1, MFHI/MFLO present in EX.
REQ-010 SHALL have port flush, input, 1, abort the in-flight operation.
REQ-011 SHALL have port busy, output, 1, high when state != IDLE.
REQ-012 SHALL have port stall_req, output, 1, pipeline stall request to the hazard logic.
REQ-013 SHALL have port done, output, 1, registered one-cycle completion pulse.
REQ-014 SHALL have ports hi and lo, output, 32 each, the architectural HI/LO registers.

Function
REQ-015 SHALL implement the FSM states IDLE, CALC and FIN; a 6-bit iteration counter SHALL be used in CALC.
REQ-016 IDLE->CALC on an edge with start=1 and flush=0: latch op and |opa|, |opb| (absolute values only for op 00/10), latch the result signs, clear counter.
REQ-017 CALC SHALL perform one radix-2 step per cycle (shift-add multiply or restoring divide) and go to FIN after exactly 32 steps.
REQ-018 FIN SHALL apply the sign fix-up, write hi/lo, return to IDLE and assert done the following cycle for exactly 1 cycle.
REQ-019 Latency SHALL be fixed: start sampled at edge E0 gives hi/lo updated at edge E33 and done high from E33 to E34; busy is high from E0 to E33 (33 cycles), independent of operand values.
REQ-020 MULT/MULTU SHALL produce the full 64-bit product, with hi = [63:32] and lo = [31:0].
REQ-021 DIV/DIVU SHALL produce lo = quotient and hi = remainder; signed division SHALL truncate toward zero and the remainder SHALL take the sign of the dividend.
REQ-022 Divide by zero SHALL give lo = 32'hFFFFFFFF and hi = opa for both signed and unsigned ops, with full latency and no exception.
REQ-023 Signed overflow (0x80000000 / -1) SHALL give lo = 32'h80000000 and hi = 0.
REQ-024 stall_req SHALL equal busy & (start | rd_hilo | hi_we | lo_we), combinationally.
REQ-025 start, hi_we and lo_we SHALL be ignored while busy; the stalled instruction re-presents them after the unit returns to IDLE.
REQ-026 In IDLE, hi_we/lo_we SHALL load wdata into hi/lo at the edge.
REQ-027 If start and hi_we/lo_we are both asserted in the same IDLE cycle, both SHALL take effect: the MTHI/MTLO write lands now, and the result overwrites it at E33.
REQ-028 flush in CALC or FIN SHALL force IDLE at the next edge, leave hi/lo unchanged and suppress done.
REQ-029 flush together with start in IDLE SHALL suppress start.
REQ-030 Internal datapath registers SHALL be 64-bit accumulator/remainder plus 32-bit divisor/multiplicand, with no combinational 32x32 multiplier.

Reset
REQ-031 On rst_n=0, asynchronously: state=IDLE, counter=0, hi=0, lo=0, done=0, busy=0, all internal operand/accumulator registers=0.
REQ-032 Reset asserted mid-CALC SHALL abandon the operation with no done pulse; operation SHALL resume only on a new start after rst_n=1.

Verification
REQ-033 MULTU opa=3, opb=5 -> busy for 33 cycles, then hi=0, lo=15, done pulses exactly once at E33.
REQ-034 MULT opa=0xFFFFFFFE (-2), opb=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-035 DIV opa=0xFFFFFFF9 (-7), opb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU opa=7, opb=0 -> lo=0xFFFFFFFF, hi=7.
REQ-036 Start MULTU, assert rd_hilo at cycle 5 -> stall_req=1 through E33, then 0; hi/lo hold the new result when stall_req drops; hi_we pulsed while busy leaves hi unaffected.
REQ-037 Preload hi=0xAAAA via hi_we, start DIV, flush at cycle 10 -> busy=0 after the next edge, no done, hi=0xAAAA; a second start then completes normally.
REQ-038 rst_n pulsed low at cycle 20 of a MULT -> outputs immediately 0, no done pulse afterwards.
